// File: rtl/t_ff_bit.sv
// rtl/t_ff_bit.sv - single-bit toggle flip-flop with asynchronous active-low reset
`timescale 1us/1ns

module t_ff_bit #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q,
  output logic qbar
);

  logic r_q;
  logic w_next;

  assign w_next = r_q ^ t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RESET_BIT;
    end else begin
      r_q <= w_next;
    end
  end

  // qbar is derived from the same register so it can never disagree with q, even in reset
  assign q    = r_q;
  assign qbar = ~r_q;

endmodule

// File: rtl/t_flip_flop_simple.sv
// rtl/t_flip_flop_simple.sv - WIDTH independent toggle flip-flops sharing clock and reset
`timescale 1us/1ns

module t_flip_flop_simple #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  if (WIDTH < 1) begin : g_bad_width
    $error("t_flip_flop_simple: WIDTH must be >= 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_bit #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t[i]),
      .q     (q[i]),
      .qbar  (qbar[i])
    );
  end

endmodule

// File: tb/tb_t_flip_flop_simple.sv
// tb/tb_t_flip_flop_simple.sv - directed self-checking bench for t_flip_flop_simple
`timescale 1us/1ns

module tb_t_flip_flop_simple;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       t1 = 1'b0;
  logic       q1;
  logic       qbar1;
  logic [3:0] t4 = 4'b0000;
  logic [3:0] q4;
  logic [3:0] qbar4;

  int n_cmp = 0;
  int n_err = 0;

  // 2 ms period: each phase lasts 1 ms
  always #1000 clk = ~clk;

  t_flip_flop_simple dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .t     (t1),
    .q     (q1),
    .qbar  (qbar1)
  );

  t_flip_flop_simple #(
    .WIDTH       (4),
    .RESET_VALUE (4'b1010)
  ) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .t     (t4),
    .q     (q4),
    .qbar  (qbar4)
  );

  task automatic do_reset_release();
    @(negedge clk);
    rst_n = 1'b0;
    #100;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    t1 = 1'b1;
    t4 = 4'b1111;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (q1 !== 1'b0 || qbar1 !== 1'b1) begin
        n_err++;
        $display("FAIL reset_hold1 edge %0d: q=%b qbar=%b required q=0 qbar=1", k, q1, qbar1);
      end
      n_cmp++;
      if (q4 !== 4'b1010 || qbar4 !== 4'b0101) begin
        n_err++;
        $display("FAIL reset_hold4 edge %0d: q=%b qbar=%b required q=1010 qbar=0101", k, q4, qbar4);
      end
    end
    rst_n = 1'b1;
    #100;
    n_cmp++;
    if (q1 !== 1'b0) begin
      n_err++;
      $display("FAIL release_no_edge: q=%b required 0", q1);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (q1 !== 1'b1 || qbar1 !== 1'b0) begin
      n_err++;
      $display("FAIL release_first_toggle: q=%b qbar=%b required q=1 qbar=0", q1, qbar1);
    end
    n_cmp++;
    if (q4 !== 4'b0101) begin
      n_err++;
      $display("FAIL release_first_toggle4: q=%b required 0101", q4);
    end
  endtask

  task automatic test_hold();
    t1 = 1'b0;
    t4 = 4'b0000;
    do_reset_release();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (q1 !== 1'b0 || qbar1 !== 1'b1) begin
        n_err++;
        $display("FAIL hold edge %0d: q=%b qbar=%b required q=0 qbar=1", k, q1, qbar1);
      end
    end
  endtask

  task automatic test_toggle();
    logic [3:0] exp_seq;
    exp_seq = 4'b0101;
    @(negedge clk);
    t1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (q1 !== exp_seq[k] || qbar1 !== ~exp_seq[k]) begin
        n_err++;
        $display("FAIL toggle edge %0d: q=%b qbar=%b required q=%b qbar=%b",
                 k, q1, qbar1, exp_seq[k], ~exp_seq[k]);
      end
    end
    @(negedge clk);
    t1 = 1'b0;
  endtask

  task automatic test_mid_cycle_t();
    logic exp_q;
    do_reset_release();
    t1 = 1'b0;
    exp_q = 1'b0;
    @(negedge clk);
    fork
      begin
        #500;
        repeat (10) begin
          #5000;
          t1 = ~t1;
        end
      end
      begin
        for (int k = 0; k < 26; k++) begin
          @(posedge clk);
          exp_q = exp_q ^ t1;
          #500;
          n_cmp++;
          if (q1 !== exp_q) begin
            n_err++;
            $display("FAIL midcycle_after_edge %0d: q=%b required %b", k, q1, exp_q);
          end
          #1000;
          n_cmp++;
          if (q1 !== exp_q || qbar1 !== ~exp_q) begin
            n_err++;
            $display("FAIL midcycle_between_edges %0d: q=%b qbar=%b required q=%b", k, q1, qbar1, exp_q);
          end
        end
      end
    join
  endtask

  task automatic test_async_reset();
    do_reset_release();
    t1 = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (q1 !== 1'b1) begin
      n_err++;
      $display("FAIL async_setup: q=%b required 1", q1);
    end
    @(negedge clk);
    t1 = 1'b0;
    #500;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (q1 !== 1'b0 || qbar1 !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset_immediate: q=%b qbar=%b required q=0 qbar=1", q1, qbar1);
    end
    n_cmp++;
    if (clk !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_between_edges: clk=%b required 0", clk);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vector();
    do_reset_release();
    t4 = 4'b0110;
    @(posedge clk);
    #1;
    n_cmp++;
    if (q4 !== 4'b1100 || qbar4 !== 4'b0011) begin
      n_err++;
      $display("FAIL vector_0110: q=%b qbar=%b required q=1100 qbar=0011", q4, qbar4);
    end
    @(negedge clk);
    t4 = 4'b0000;
    @(posedge clk);
    #1;
    n_cmp++;
    if (q4 !== 4'b1100) begin
      n_err++;
      $display("FAIL vector_hold: q=%b required 1100", q4);
    end
    @(negedge clk);
    t4 = 4'b1001;
    @(posedge clk);
    #1;
    n_cmp++;
    if (q4 !== 4'b0101 || qbar4 !== 4'b1010) begin
      n_err++;
      $display("FAIL vector_1001: q=%b qbar=%b required q=0101 qbar=1010", q4, qbar4);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] t_tab [4];
    logic [3:0] q_tab [4];
    t_tab = '{4'b1111, 4'b0001, 4'b1000, 4'b1111};
    q_tab = '{4'b1010, 4'b1011, 4'b0011, 4'b1100};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      t4 = t_tab[k];
      @(posedge clk);
      #1;
      n_cmp++;
      if (q4 !== q_tab[k] || qbar4 !== ~q_tab[k]) begin
        n_err++;
        $display("FAIL back_to_back %0d: q=%b qbar=%b required q=%b", k, q4, qbar4, q_tab[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_toggle();
    test_mid_cycle_t();
    test_async_reset();
    test_vector();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
